// File: rtl/cmult_pipe_rs.sv
// rtl/cmult_pipe_rs.sv - pipelined 3-multiplier complex multiplier with rounding and narrowing
//
// Computes p = a * b (or a * conj(b) when conj is set with the sample) using
// three real multipliers that share the term (ar - ai) * bi:
//    pr = ar*(br - bi) + bi*(ar - ai)
//    pi = ai*(br + bi) + bi*(ar - ai)
// The conjugate case reuses the same datapath with bi negated on entry.
//
// Pipeline: 6 arithmetic stages + 1 round/narrow stage, 7 enabled cycles
// from in_valid to out_valid, one sample per enabled cycle, no backpressure.
//
// Build option: define CMULT_SAT_EN to clamp out-of-range results and raise
// ovf; otherwise results wrap to OWIDTH bits and ovf stays 0.
//
// Ports:
//    clk        rising-edge clock
//    rst        synchronous active-high reset (clears valid pipe and outputs)
//    ce         clock enable; low freezes every register
//    in_valid   input sample qualifier
//    conj       multiply by conj(b) for this sample
//    ar, ai     signed a operand, AWIDTH bits
//    br, bi     signed b operand, BWIDTH bits
//    out_valid  output qualifier
//    pr, pi     signed product, OWIDTH bits, held while out_valid is low
//    ovf        saturation occurred on pr or pi for this output sample
module cmult_pipe_rs #(
   parameter int AWIDTH = 18,
   parameter int BWIDTH = 18,
   parameter int OWIDTH = 37,
   parameter int SHIFT  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     in_valid,
   input  logic                     conj,
   input  logic signed [AWIDTH-1:0] ar,
   input  logic signed [AWIDTH-1:0] ai,
   input  logic signed [BWIDTH-1:0] br,
   input  logic signed [BWIDTH-1:0] bi,
   output logic                     out_valid,
   output logic signed [OWIDTH-1:0] pr,
   output logic signed [OWIDTH-1:0] pi,
   output logic                     ovf
);

   // Full-precision product width is AWIDTH+BWIDTH+1; the intermediate
   // partial products of the 3-multiplier form need one more bit, and the
   // post-adders and rounding bias one more again.
   localparam int F = AWIDTH + BWIDTH + 1;
   localparam int W = F + 2;

   // Half an output LSB, zero when no scaling is applied.
   localparam logic signed [W-1:0] RND = (W'(1) << SHIFT) >>> 1;

   // Stage 1: operand capture; bi is widened by one bit so that negating
   // the most negative value is exact.
   logic signed [AWIDTH-1:0] s1_ar, s1_ai;
   logic signed [BWIDTH-1:0] s1_br;
   logic signed [BWIDTH:0]   s1_bi;

   // Stage 2: pre-adders.
   logic signed [AWIDTH:0]   s2_d;
   logic signed [BWIDTH+1:0] s2_sr, s2_si;
   logic signed [AWIDTH-1:0] s2_ar, s2_ai;
   logic signed [BWIDTH:0]   s2_bi;

   // Stages 3-4: multipliers, registered twice so they can map onto
   // pipelined DSP blocks.
   logic signed [W-1:0] s3_mr, s3_mi, s3_mc;
   logic signed [W-1:0] s4_mr, s4_mi, s4_mc;

   // Stage 5: post-adders (full precision). Stage 6: rounding bias.
   logic signed [W-1:0] s5_r, s5_i;
   logic signed [W-1:0] s6_r, s6_i;

   // Valid tracking for stages 1..6; stage 7 is out_valid itself.
   logic [5:0] vp;

   // Narrowed result with its overflow flag in the top bit.
   logic [OWIDTH:0] nr, ni;

`ifdef CMULT_SAT_EN
   function automatic logic [OWIDTH:0] narrow(input logic signed [W-1:0] v);
      logic signed [W-1:0] s;
      logic [W-OWIDTH:0]   hi;
      s  = v >>> SHIFT;
      hi = s[W-1:OWIDTH-1];
      // In range when every bit from the output sign bit upward agrees.
      if (&hi || ~|hi)
         return {1'b0, s[OWIDTH-1:0]};
      else if (s[W-1])
         return {1'b1, 1'b1, {(OWIDTH-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(OWIDTH-1){1'b1}}};
   endfunction
`else
   function automatic logic [OWIDTH:0] narrow(input logic signed [W-1:0] v);
      return {1'b0, OWIDTH'(v >>> SHIFT)};
   endfunction
`endif

   assign nr = narrow(s6_r);
   assign ni = narrow(s6_i);

   // Datapath registers: no reset needed, garbage is masked by the valid pipe.
   always_ff @(posedge clk) begin
      if (ce) begin
         s1_ar <= ar;
         s1_ai <= ai;
         s1_br <= br;
         s1_bi <= conj ? -((BWIDTH+1)'(bi)) : (BWIDTH+1)'(bi);

         s2_d  <= (AWIDTH+1)'(s1_ar) - (AWIDTH+1)'(s1_ai);
         s2_sr <= (BWIDTH+2)'(s1_br) - (BWIDTH+2)'(s1_bi);
         s2_si <= (BWIDTH+2)'(s1_br) + (BWIDTH+2)'(s1_bi);
         s2_ar <= s1_ar;
         s2_ai <= s1_ai;
         s2_bi <= s1_bi;

         s3_mc <= W'(s2_d)  * W'(s2_bi);
         s3_mr <= W'(s2_ar) * W'(s2_sr);
         s3_mi <= W'(s2_ai) * W'(s2_si);

         s4_mc <= s3_mc;
         s4_mr <= s3_mr;
         s4_mi <= s3_mi;

         s5_r  <= s4_mr + s4_mc;
         s5_i  <= s4_mi + s4_mc;

         s6_r  <= s5_r + RND;
         s6_i  <= s5_i + RND;
      end
   end

   // Control and output registers: reset wins over ce.
   always_ff @(posedge clk) begin
      if (rst) begin
         vp        <= '0;
         out_valid <= 1'b0;
         pr        <= '0;
         pi        <= '0;
         ovf       <= 1'b0;
      end else if (ce) begin
         vp        <= {vp[4:0], in_valid};
         out_valid <= vp[5];
         // Outputs only move for a real sample so they hold across gaps.
         if (vp[5]) begin
            pr  <= nr[OWIDTH-1:0];
            pi  <= ni[OWIDTH-1:0];
            ovf <= nr[OWIDTH] | ni[OWIDTH];
         end
      end
   end

endmodule

// File: doc/cmult_pipe_rs.md
# cmult_pipe_rs

Parameterised, fully pipelined complex multiplier with valid tracking, clock enable, per-sample conjugate mode and rounded, scaled output. It uses three real multipliers, with the shared term (ar-ai)*bi. It is the next-generation complex-product stage feeding the FIR/mixer datapath. It accepts one sample per enabled cycle.

## Interface
- AWIDTH, 18: signed width of ar, ai.
- BWIDTH, 18: signed width of br, bi.
- OWIDTH, 37: signed width of pr, pi. Must be ≥ 2 and ≤ AWIDTH+BWIDTH+1.
- SHIFT, 0: right-shift applied to the full-precision result before output. Range 0..AWIDTH+BWIDTH.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable. When low, the whole pipeline holds.
- in_valid  in  1  input sample qualifier.
- conj  in  1  when 1, multiply by conj(b), sampled with in_valid.
- ar, ai  in  AWIDTH  signed a operand.
- br, bi  in  BWIDTH  signed b operand.
- out_valid  out  1  output qualifier.
- pr, pi  out  OWIDTH  signed product.
- ovf  out  1  saturation occurred on pr or pi for this output sample. Qualified by out_valid.

## Operation
- conj=0: P_r = ar·br − ai·bi; P_i = ar·bi + ai·br.
- conj=1: P_r = ar·br + ai·bi; P_i = ai·br − ar·bi. Implemented by negating bi at stage 1 into BWIDTH+1 bits, so −2^(BWIDTH−1) negates exactly.
- Full-precision width F = AWIDTH+BWIDTH+1. F is exact for all inputs, including all-minimum corners. Internal sums carry ≥ F+1 bits; the result must be bit-exact.
- Scaling, when SHIFT>0: R = (P + 2^(SHIFT−1)) >>> SHIFT, which is round-half-up (toward +∞ at ties). When SHIFT=0: R = P.
- Narrowing R to OWIDTH: see Configuration.
- in_valid and conj travel in a shift register alongside the data. A low in_valid still clocks data through; out_valid is simply low for that slot.
- No backpressure. The consumer must accept every out_valid cycle.

## Timing
- Latency is 7 enabled cycles from in_valid sampled to out_valid: 6 arithmetic stages plus 1 round/narrow stage.
- Throughput is 1 sample per enabled cycle. Back-to-back samples and arbitrary valid gaps are supported.
- ce=0 freezes every register, including the valid pipe and outputs. Nothing is dropped or duplicated. Latency counts only ce=1 edges.
- rst=1 at a rising edge, regardless of ce:
  - valid pipe, out_valid, pr, pi and ovf go to 0.
  - In-flight samples are discarded.
  - Data registers other than the outputs need no reset.
- rst has priority over ce and in_valid in the same cycle.
- First output is possible 7 enabled cycles after the first sample accepted post-reset.
- pr, pi and ovf hold their last value while out_valid=0. They change only on an enabled edge.

## Configuration
- CMULT_SAT_EN defined:
  - R outside [−2^(OWIDTH−1), 2^(OWIDTH−1)−1] clamps to the nearest bound.
  - ovf=1 for that output if either component clamped.
- CMULT_SAT_EN undefined:
  - R is truncated to its low OWIDTH bits (two's-complement wrap).
  - ovf is constant 0.
- When OWIDTH ≥ F−SHIFT+1, both builds give identical pr/pi.

## Test plan
- Defaults. Input (3+4j)·(5+6j), conj=0, single valid pulse → exactly one out_valid, 7 cycles later, with pr=−9, pi=38, ovf=0.
- Defaults. Input (3+4j), b=(5+6j), conj=1 → pr=39, pi=2. Then ar=ai=br=bi=−131072 with conj=1 → pr=34359738368, pi=0.
- OWIDTH=18, SHIFT=17, same all-minimum conj=1 sample:
  - With CMULT_SAT_EN: pr=131071, pi=0, ovf=1.
  - Without CMULT_SAT_EN: pr=0, pi=0, ovf=0.
- SHIFT=1, OWIDTH=37:
  - (3+0j)·(1+0j) → pr=2.
  - (−3+0j)·(1+0j) → pr=−1.
  - (1+0j)·(1+0j) → pr=1.
- Stream 20 random samples with random in_valid gaps and random ce=0 cycles → outputs match the reference model in order, with latency of 7 ce=1 edges. Outputs and out_valid stay frozen while ce=0.
- Assert rst for 1 cycle while 4 samples are in flight → out_valid=0 and pr=pi=0 on the next edge. No stale sample ever appears. A sample issued the cycle after rst deasserts emerges 7 cycles later.
